// File: rtl/fs_port_arbiter.sv
`timescale 1ns/1ps
// fs_port_arbiter: shares the single framestore bus port between the edge
// detector (port 0) and the drawing/host engine (port 1). Round-robin on
// contention, one transaction in flight, grant held until fs_ack or until
// the watchdog expires.
//
// Handshake: a requester raises mX_req with addr/rnw/nbyte/w_data stable and
// holds everything until mX_ack, a one-cycle pulse (mX_err rides along on a
// timeout); it must drop or re-present req by the following cycle. Toward the
// framestore, fs_req stays high with stable fs_* until the fs_ack pulse, and
// read data is valid in the fs_ack cycle.
module fs_port_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rnw,
  input  logic [3:0]        m0_nbyte,
  input  logic [DATA_W-1:0] m0_w_data,
  input  logic              m1_req,
  output logic              m1_ack,
  output logic              m1_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rnw,
  input  logic [3:0]        m1_nbyte,
  input  logic [DATA_W-1:0] m1_w_data,
  output logic [DATA_W-1:0] r_data,
  output logic              fs_req,
  input  logic              fs_ack,
  output logic [ADDR_W-1:0] fs_addr,
  output logic              fs_rnw,
  output logic [3:0]        fs_nbyte,
  output logic [DATA_W-1:0] fs_w_data,
  input  logic [DATA_W-1:0] fs_r_data,
  output logic              owner,
  output logic [1:0]        state_dbg
);

  // Counter only has to reach TIMEOUT-1; it is cleared on every grant.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack0_d, ack1_d, err0_d, err1_d;
  logic [DATA_W-1:0]  r_data_d;

  // State, grant select, round-robin pointer, watchdog and registered acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      owner_q <= 1'b1;
      cnt_q   <= '0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      r_data  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      m0_ack  <= ack0_d;
      m1_ack  <= ack1_d;
      m0_err  <= err0_d;
      m1_err  <= err1_d;
      r_data  <= r_data_d;
    end
  end

  // Next-state: arbitrate in IDLE, wait for ack or timeout in BUSY, and
  // spend one RELEASE cycle so a stale req of the acked port is not regranted.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    r_data_d = r_data;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // On contention the port that did not own the bus last wins.
          sel_d   = (m0_req && m1_req) ? ~owner_q : m1_req;
          owner_d = sel_d;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (fs_ack) begin
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          if (fs_rnw) r_data_d = fs_r_data;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ack0_d   = ~sel_q;
          ack1_d   = sel_q;
          err0_d   = ~sel_q;
          err1_d   = sel_q;
          r_data_d = '0;
          state_d  = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Framestore side: request tracks BUSY, payload muxed on the registered select.
  assign fs_req    = (state_q == ST_BUSY);
  assign fs_addr   = sel_q ? m1_addr   : m0_addr;
  assign fs_rnw    = sel_q ? m1_rnw    : m0_rnw;
  assign fs_nbyte  = sel_q ? m1_nbyte  : m0_nbyte;
  assign fs_w_data = sel_q ? m1_w_data : m0_w_data;
  assign owner     = owner_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fs_port_arbiter.sv
`timescale 1ns/1ps
// Bench for fs_port_arbiter: directed transactions on both ports, a simple
// framestore responder with programmable ack latency, a transaction-level
// reference model compared every cycle, and literal checks per scenario.
module tb_fs_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req = 0, m0_rnw = 0, m1_req = 0, m1_rnw = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [3:0]    m0_nbyte = '0, m1_nbyte = '0;
  logic [DW-1:0] m0_w_data = '0, m1_w_data = '0;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] r_data, fs_w_data;
  logic [DW-1:0] fs_r_data = '0;
  logic          fs_req, fs_rnw, owner;
  logic          fs_ack = 1'b0;
  logic [AW-1:0] fs_addr;
  logic [3:0]    fs_nbyte;
  logic [1:0]    state_dbg;

  fs_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_ack(m0_ack), .m0_err(m0_err), .m0_addr(m0_addr),
    .m0_rnw(m0_rnw), .m0_nbyte(m0_nbyte), .m0_w_data(m0_w_data),
    .m1_req(m1_req), .m1_ack(m1_ack), .m1_err(m1_err), .m1_addr(m1_addr),
    .m1_rnw(m1_rnw), .m1_nbyte(m1_nbyte), .m1_w_data(m1_w_data),
    .r_data(r_data), .fs_req(fs_req), .fs_ack(fs_ack), .fs_addr(fs_addr),
    .fs_rnw(fs_rnw), .fs_nbyte(fs_nbyte), .fs_w_data(fs_w_data),
    .fs_r_data(fs_r_data), .owner(owner), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- framestore responder ----------------
  // fs_lat = N acks in the Nth cycle of a request; 0 never acks.
  int fs_lat = 0;
  int busy_n = 0;
  always @(posedge clk) begin
    #1;
    if (fs_req) begin
      busy_n++;
      fs_ack = (fs_lat != 0 && busy_n == fs_lat);
    end else begin
      busy_n = 0;
      fs_ack = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // A transaction occupies the bus until acked or until TO cycles passed
  // without ack; after it completes the bus sits out one cycle, then any
  // pending request may be granted (alternating on contention).
  bit            m_busy = 0, m_cool = 0, m_owner = 1;
  bit            m_ack0 = 0, m_ack1 = 0, m_err0 = 0, m_err1 = 0;
  int            m_port = 0, m_wait = 0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk) begin
    m_ack0 = 0; m_ack1 = 0; m_err0 = 0; m_err1 = 0;
    if (rst) begin
      m_busy = 0; m_cool = 0; m_owner = 1; m_wait = 0; m_rdata = '0;
    end else if (m_busy) begin
      bit done, timed_out;
      done = 0; timed_out = 0;
      if (fs_ack) done = 1;
      else begin
        m_wait++;
        if (m_wait == TO) begin done = 1; timed_out = 1; end
      end
      if (done) begin
        if (m_port == 0) begin m_ack0 = 1; m_err0 = timed_out; end
        else begin m_ack1 = 1; m_err1 = timed_out; end
        if (timed_out) m_rdata = '0;
        else if ((m_port == 0) ? m0_rnw : m1_rnw) m_rdata = fs_r_data;
        m_busy = 0;
        m_cool = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (m0_req || m1_req) begin
      if (m0_req && m1_req) m_port = m_owner ? 0 : 1;
      else m_port = m0_req ? 0 : 1;
      m_owner = m_port[0];
      m_busy  = 1;
      m_wait  = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("fs_req", fs_req, m_busy);
      if (m_busy) begin
        chk("fs_addr",   fs_addr,   (m_port == 0) ? m0_addr   : m1_addr);
        chk("fs_rnw",    fs_rnw,    (m_port == 0) ? m0_rnw    : m1_rnw);
        chk("fs_nbyte",  fs_nbyte,  (m_port == 0) ? m0_nbyte  : m1_nbyte);
        chk("fs_w_data", fs_w_data, (m_port == 0) ? m0_w_data : m1_w_data);
      end
      chk("owner",  owner,  m_owner);
      chk("m0_ack", m0_ack, m_ack0);
      chk("m1_ack", m1_ack, m_ack1);
      chk("m0_err", m0_err, m_err0);
      chk("m1_err", m1_err, m_err1);
      if (m_ack0 || m_ack1) chk("r_data", r_data, m_rdata);
    end
  end

  // ---------------- bus monitor / logs ----------------
  int            cyc = 0;
  bit            prev_req = 0;
  int            hi_len = 0;
  int            g_owner[$], g_cyc[$], len_q[$];
  logic [AW-1:0] g_addr[$];
  logic          g_rnw[$];
  logic [3:0]    g_nbyte[$];
  logic [DW-1:0] g_wdata[$];
  int            ack0_cnt = 0, ack1_cnt = 0, err0_cnt = 0, err1_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fs_req) begin
      if (!prev_req) begin
        g_owner.push_back(int'(owner)); g_cyc.push_back(cyc);
        g_addr.push_back(fs_addr); g_rnw.push_back(fs_rnw);
        g_nbyte.push_back(fs_nbyte); g_wdata.push_back(fs_w_data);
        hi_len = 0;
      end
      hi_len++;
    end else if (prev_req) begin
      len_q.push_back(hi_len);
    end
    prev_req = fs_req;
    if (m0_ack) ack0_cnt++;
    if (m1_ack) ack1_cnt++;
    if (m0_err) err0_cnt++;
    if (m1_err) err1_cnt++;
  end

  task automatic clear_logs();
    g_owner.delete(); g_cyc.delete(); len_q.delete(); g_addr.delete();
    g_rnw.delete(); g_nbyte.delete(); g_wdata.delete();
    ack0_cnt = 0; ack1_cnt = 0; err0_cnt = 0; err1_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Called just after a posedge; returns just after the posedge following ack.
  task automatic txn(input int p, input logic [AW-1:0] a, input logic rnw,
                     input logic [3:0] nb, input logic [DW-1:0] wd, input bit keep,
                     output logic [DW-1:0] rd, output bit er);
    int n;
    bit got;
    if (p == 0) begin
      m0_addr = a; m0_rnw = rnw; m0_nbyte = nb; m0_w_data = wd; m0_req = 1'b1;
    end else begin
      m1_addr = a; m1_rnw = rnw; m1_nbyte = nb; m1_w_data = wd; m1_req = 1'b1;
    end
    n = 0; got = 0; rd = '0; er = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if ((p == 0) ? m0_ack : m1_ack) begin
        got = 1;
        rd  = r_data;
        er  = (p == 0) ? m0_err : m1_err;
      end
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL txn_wait port %0d: no ack within 100 cycles, required an ack", p);
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  logic [DW-1:0] rd0, rd1, rd2, rd3;
  bit            er0, er1, er2, er3;

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_fs_req", fs_req, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_r_data", r_data, 32'h0);
    chk("rst_owner",  owner,  1'b1);

    // Both ports contend continuously for two transactions each (writes)
    @(posedge clk); #1;
    fs_lat = 1;
    clear_logs();
    fork
      begin
        txn(0, 18'h00100, 1'b0, 4'h0, 32'h11110000, 1, rd0, er0);
        txn(0, 18'h00101, 1'b0, 4'h0, 32'h11110001, 0, rd0, er0);
      end
      begin
        txn(1, 18'h00200, 1'b0, 4'h0, 32'h22220000, 1, rd1, er1);
        txn(1, 18'h00201, 1'b0, 4'h0, 32'h22220001, 0, rd1, er1);
      end
    join
    chk("rr_grants", g_owner.size(), 4);
    chk("rr_owner0", g_owner[0], 0);
    chk("rr_owner1", g_owner[1], 1);
    chk("rr_owner2", g_owner[2], 0);
    chk("rr_owner3", g_owner[3], 1);
    chk("rr_addr0", g_addr[0], 18'h00100);
    chk("rr_addr1", g_addr[1], 18'h00200);
    chk("rr_addr2", g_addr[2], 18'h00101);
    chk("rr_addr3", g_addr[3], 18'h00201);
    for (int i = 1; i < 4; i++) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], 3);

    // m0 read, ack in the 3rd request cycle
    fs_lat = 3;
    fs_r_data = 32'h0A0B0C0D;
    clear_logs();
    txn(0, 18'h00010, 1'b1, 4'h0, 32'h0, 0, rd0, er0);
    chk("rd_req_len", len_q[0], 3);
    chk("rd_addr", g_addr[0], 18'h00010);
    chk("rd_rnw", g_rnw[0], 1'b1);
    chk("rd_data", rd0, 32'h0A0B0C0D);
    chk("rd_err", er0, 1'b0);
    chk("rd_ack0_cnt", ack0_cnt, 1);
    chk("rd_ack1_cnt", ack1_cnt, 0);

    // m1 write at the top address, r_data must keep the previous read
    fs_lat = 2;
    fs_r_data = 32'h77777777;
    clear_logs();
    txn(1, 18'h3FFFF, 1'b0, 4'b0101, 32'hDEADBEEF, 0, rd1, er1);
    chk("wr_addr", g_addr[0], 18'h3FFFF);
    chk("wr_rnw", g_rnw[0], 1'b0);
    chk("wr_nbyte", g_nbyte[0], 4'b0101);
    chk("wr_wdata", g_wdata[0], 32'hDEADBEEF);
    chk("wr_rdata_held", rd1, 32'h0A0B0C0D);
    chk("wr_ack1_cnt", ack1_cnt, 1);
    chk("wr_ack0_cnt", ack0_cnt, 0);

    // Watchdog: m0 read never acked, m1 pending behind it
    fs_lat = 0;
    fs_r_data = 32'h55AA55AA;
    clear_logs();
    fork
      txn(0, 18'h00020, 1'b1, 4'h0, 32'h0, 0, rd2, er2);
      begin
        repeat (2) begin @(posedge clk); #1; end
        txn(1, 18'h00030, 1'b1, 4'h0, 32'h0, 0, rd3, er3);
      end
      begin
        int n;
        n = 0;
        while (!m0_ack && n < 50) begin @(negedge clk); n++; end
        fs_lat = 2;
      end
    join
    chk("to_req_len", len_q[0], TO);
    chk("to_err", er2, 1'b1);
    chk("to_rdata", rd2, 32'h0);
    chk("to_err0_cnt", err0_cnt, 1);
    chk("to_next_owner", g_owner[1], 1);
    chk("to_m1_rdata", rd3, 32'h55AA55AA);
    chk("to_m1_err", er3, 1'b0);

    // Reset in the 2nd busy cycle abandons the request silently
    fs_lat = 0;
    clear_logs();
    m0_addr = 18'h00040; m0_rnw = 1'b1; m0_nbyte = 4'h0; m0_req = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!fs_req && n < 20);
      chk("rst_mid_granted", fs_req, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b1; m0_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_fs_req", fs_req, 1'b0);
    chk("rst_mid_owner", owner, 1'b1);
    chk("rst_mid_acks", ack0_cnt + ack1_cnt, 0);
    chk("rst_mid_errs", err0_cnt + err1_cnt, 0);
    @(posedge clk); #1;
    fs_lat = 2;
    fs_r_data = 32'h01020304;
    txn(0, 18'h00040, 1'b1, 4'h0, 32'h0, 0, rd0, er0);
    chk("rst_after_rdata", rd0, 32'h01020304);
    chk("rst_after_ack0", ack0_cnt, 1);

    // m0 keeps req high past its ack: regranted only after RELEASE + IDLE
    fs_lat = 1;
    clear_logs();
    txn(0, 18'h00050, 1'b1, 4'h0, 32'h0, 1, rd0, er0);
    txn(0, 18'h00051, 1'b1, 4'h0, 32'h0, 0, rd0, er0);
    chk("stale_grants", g_cyc.size(), 2);
    chk("stale_spacing", g_cyc[1] - g_cyc[0], 3);
    chk("stale_addr1", g_addr[1], 18'h00051);
    chk("stale_ack0", ack0_cnt, 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    n_errors++;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
